// File: rtl/seg_595_scan_multi.sv
// Dynamic-scan seven-segment driver for a 74HC595 chain. A free-running
// double-dabble turns the binary input into BCD, and one digit frame is sent per scan slot.
module seg_595_scan_multi #(
    parameter int NUM_DIG  = 6,
    parameter int DATA_W   = 20,
    parameter int SCAN_CNT = 50_000,
    parameter int CLK_DIV  = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [DATA_W-1:0]  data,
    input  logic [NUM_DIG-1:0] point,
    input  logic               sign,
    input  logic               seg_en,
    input  logic               lz_blank,
    output logic               ds,
    output logic               shcp,
    output logic               stcp,
    output logic               oe
);
    localparam int F     = 8 + NUM_DIG;
    localparam int BCD_W = 4 * NUM_DIG;
    localparam int CNT_W = $clog2(SCAN_CNT);
    localparam int DIG_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(F + 2);
    localparam int SH_W  = $clog2(DATA_W + 1);

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int j = 0; j < n; j++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(NUM_DIG);

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load, w_shift, w_done;
    logic [DATA_W-1:0]  r_bin;
    logic [BCD_W-1:0]   r_work, w_adj, r_bcd;
    logic [SH_W-1:0]    r_sh_cnt;
    logic               r_ovf_cap, r_ovf;

    logic [CNT_W-1:0]   r_cnt;
    logic [DIG_W-1:0]   r_dig;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [F-1:0]       r_frame, w_frame;
    logic [3:0]         w_dig;
    logic               w_lz_zero, w_pt, w_ds_bit;
    logic [7:0]         w_seg;
    logic [NUM_DIG-1:0] w_sel;
    logic               r_ds, r_shcp, r_stcp, r_oe;

    // converter state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // converter next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: w_state_nxt = (r_sh_cnt == SH_W'(DATA_W - 1)) ? S_DONE : S_SHIFT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // converter decode and add-3 correction of every BCD nibble
    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_LOAD:  w_load  = 1'b1;
            S_SHIFT: w_shift = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: w_load  = 1'b0;
        endcase
        w_adj = r_work;
        for (int j = 0; j < NUM_DIG; j++)
            w_adj[4*j +: 4] = (r_work[4*j +: 4] >= 4'd5) ? r_work[4*j +: 4] + 4'd3 : r_work[4*j +: 4];
    end

    // converter datapath; the display only ever sees r_bcd/r_ovf
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bin     <= '0;
            r_work    <= '0;
            r_sh_cnt  <= '0;
            r_ovf_cap <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_bin     <= data;
            r_work    <= '0;
            r_sh_cnt  <= '0;
            r_ovf_cap <= (64'(data) > MAX_VAL);
        end else if (w_shift) begin
            r_work    <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
            r_bin     <= {r_bin[DATA_W-2:0], 1'b0};
            r_sh_cnt  <= r_sh_cnt + SH_W'(1);
        end else if (w_done) begin
            r_bcd     <= r_work;
            r_ovf     <= r_ovf_cap;
        end else begin
            r_bcd     <= r_bcd;
        end
    end

    // segment code of the digit currently being scanned
    always_comb begin
        w_dig     = 4'd0;
        w_lz_zero = 1'b1;
        for (int j = 0; j < NUM_DIG; j++) begin
            w_dig     = (DIG_W'(j) == r_dig) ? r_bcd[4*j +: 4] : w_dig;
            w_lz_zero = w_lz_zero & ~((DIG_W'(j) >= r_dig) && (r_bcd[4*j +: 4] != 4'd0));
        end
        if (!seg_en)                                         w_seg = 8'hFF;
        else if (r_ovf)                                      w_seg = 8'hBF;
        else if (sign && (r_dig == DIG_W'(NUM_DIG - 1)))     w_seg = 8'hBF;
        else if (lz_blank && (r_dig != '0) && w_lz_zero)     w_seg = 8'hFF;
        else                                                 w_seg = seg_code(w_dig);
        w_pt     = seg_en & point[r_dig];
        w_sel    = NUM_DIG'(1) << r_dig;
        w_frame  = {w_seg & ~{w_pt, 7'b0}, w_sel};
        w_ds_bit = (r_cnt == '0) ? w_frame[F-1] : r_frame[F-1];
    end

    // slot counter, digit index and bit timing counters
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= '0;
            r_dig <= '0;
            r_div <= '0;
            r_bit <= '0;
        end else if (r_cnt == CNT_W'(SCAN_CNT - 1)) begin
            r_cnt <= '0;
            r_div <= '0;
            r_bit <= '0;
            r_dig <= (r_dig == DIG_W'(NUM_DIG - 1)) ? '0 : r_dig + DIG_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_div == DIV_W'(2 * CLK_DIV - 1)) begin
                r_div <= '0;
                r_bit <= (r_bit == BIT_W'(F + 1)) ? r_bit : r_bit + BIT_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // frame shift register and registered 595 pins; bit 0 comes straight from w_frame at count 0
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_frame <= '0;
            r_ds    <= 1'b0;
            r_shcp  <= 1'b0;
            r_stcp  <= 1'b0;
            r_oe    <= 1'b1;
        end else begin
            r_oe <= 1'b0;
            if (r_cnt == '0)                              r_frame <= w_frame;
            else if (r_div == DIV_W'(2 * CLK_DIV - 1))    r_frame <= {r_frame[F-2:0], 1'b0};
            else                                          r_frame <= r_frame;
            if (r_bit < BIT_W'(F)) begin
                r_ds   <= w_ds_bit;
                r_shcp <= (r_div >= DIV_W'(CLK_DIV));
                r_stcp <= 1'b0;
            end else if ((r_bit == BIT_W'(F)) && (r_div < DIV_W'(CLK_DIV))) begin
                r_ds   <= 1'b0;
                r_shcp <= 1'b0;
                r_stcp <= 1'b1;
            end else begin
                r_ds   <= 1'b0;
                r_shcp <= 1'b0;
                r_stcp <= 1'b0;
            end
        end
    end

    assign ds   = r_ds;
    assign shcp = r_shcp;
    assign stcp = r_stcp;
    assign oe   = r_oe;
endmodule

// File: tb/tb_seg_595_scan_multi.sv
// Self-checking bench for seg_595_scan_multi: frames are rebuilt from the 595 pins
// and compared with a decimal-arithmetic reference model.
module tb_seg_595_scan_multi;
    localparam int NUM_DIG  = 6;
    localparam int DATA_W   = 20;
    localparam int SCAN_CNT = 200;
    localparam int CLK_DIV  = 2;
    localparam int F        = 8 + NUM_DIG;
    localparam int unsigned MAXV = 999_999;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic [DATA_W-1:0]  data = '0;
    logic [NUM_DIG-1:0] point = '0;
    logic               sign = 1'b0, seg_en = 1'b1, lz_blank = 1'b0;
    logic               ds, shcp, stcp, oe;

    int nvec = 0, nfail = 0, cyc = 0, stcp_rises = 0;
    logic [F-1:0] fq[$];
    int           bq[$];
    int           tq[$];
    logic [F-1:0] acc = '0;
    int           nbits = 0;
    logic         p_shcp = 1'b0, p_stcp = 1'b0;
    logic [7:0]   seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_595_scan_multi #(.NUM_DIG(NUM_DIG), .DATA_W(DATA_W), .SCAN_CNT(SCAN_CNT), .CLK_DIV(CLK_DIV)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data(data), .point(point), .sign(sign),
        .seg_en(seg_en), .lz_blank(lz_blank), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // pin-level receiver: a 595 chain shifting on shcp rise, latching on stcp rise
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            acc   = '0;
            nbits = 0;
        end else begin
            if (shcp && !p_shcp) begin
                acc = {acc[F-2:0], ds};
                nbits++;
            end
            if (stcp && !p_stcp) begin
                fq.push_back(acc);
                bq.push_back(nbits);
                tq.push_back(cyc);
                stcp_rises++;
                acc   = '0;
                nbits = 0;
            end
        end
        p_shcp = shcp;
        p_stcp = stcp;
    end

    function automatic logic [F-1:0] model_frame(input int unsigned d, input logic [NUM_DIG-1:0] pt,
                                                 input logic sg, input logic en, input logic lz, input int i);
        int unsigned p10;
        logic [7:0]  s;
        p10 = 1;
        for (int j = 0; j < i; j++) p10 = p10 * 10;
        if (!en)                          s = 8'hFF;
        else if (d > MAXV)                s = 8'hBF;
        else if (sg && i == NUM_DIG - 1)  s = 8'hBF;
        else if (lz && i > 0 && d < p10)  s = 8'hFF;
        else                              s = seg_tab[(d / p10) % 10];
        if (en && pt[i]) s[7] = 1'b0;
        return {s, NUM_DIG'(1) << i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic wait_rises(input int n);
        int start, c;
        start = stcp_rises;
        c = 0;
        while (stcp_rises < start + n && c < (n + 1) * SCAN_CNT) begin
            @(posedge sys_clk);
            c++;
        end
        chk("stcp_wait", 32'(stcp_rises >= start + n), 32'd1);
    endtask

    task automatic apply(input int unsigned d, input logic [NUM_DIG-1:0] pt, input logic sg,
                         input logic en, input logic lz);
        @(negedge sys_clk);
        data = DATA_W'(d); point = pt; sign = sg; seg_en = en; lz_blank = lz;
        wait_rises(2);
    endtask

    function automatic int dig_of(input logic [F-1:0] f);
        int i;
        i = 0;
        for (int j = NUM_DIG - 1; j >= 0; j--) if (f[j]) i = j;
        return i;
    endfunction

    task automatic check_frames(input int n, input string tag);
        int c, i, prev;
        @(posedge sys_clk);
        fq.delete(); bq.delete(); tq.delete();
        c = 0;
        while (fq.size() < n && c < (n + 1) * SCAN_CNT) begin
            @(posedge sys_clk);
            c++;
        end
        chk({tag, "_count"}, 32'(fq.size()), 32'(n));
        prev = 0;
        for (int k = 0; k < fq.size(); k++) begin
            i = dig_of(fq[k]);
            chk({tag, "_frame"}, 32'(fq[k]), 32'(model_frame(int'(data), point, sign, seg_en, lz_blank, i)));
            chk({tag, "_bits"}, 32'(bq[k]), 32'(F));
            if (k > 0) begin
                chk({tag, "_order"}, 32'(i), 32'((prev + 1) % NUM_DIG));
                chk({tag, "_period"}, 32'(tq[k] - tq[k-1]), 32'(SCAN_CNT));
            end
            prev = i;
        end
    endtask

    task automatic sync_in_frame();
        int c;
        wait_rises(1);
        c = 0;
        while (!shcp && c < 2 * SCAN_CNT) begin
            @(negedge sys_clk);
            c++;
        end
        chk("sync_shcp", 32'(shcp), 32'd1);
        adv(10);
    endtask

    initial begin
        int r0;
        int unsigned d;
        data = DATA_W'(123456);
        adv(10);
        chk("rst_ds", 32'(ds), 32'd0);
        chk("rst_shcp", 32'(shcp), 32'd0);
        chk("rst_stcp", 32'(stcp), 32'd0);
        chk("rst_oe", 32'(oe), 32'd1);
        sys_rst = 1'b0;
        adv(1);
        chk("e1_oe", 32'(oe), 32'd0);
        chk("e1_shcp", 32'(shcp), 32'd0);
        chk("e1_ds", 32'(ds), 32'd1);
        adv(1);
        chk("e2_shcp", 32'(shcp), 32'd0);
        adv(1);
        chk("e3_shcp", 32'(shcp), 32'd1);
        adv(53);
        chk("e56_stcp", 32'(stcp), 32'd0);
        adv(1);
        chk("e57_stcp", 32'(stcp), 32'd1);
        chk("e57_shcp", 32'(shcp), 32'd0);
        adv(1);
        chk("e58_stcp", 32'(stcp), 32'd1);
        adv(1);
        chk("e59_stcp", 32'(stcp), 32'd0);
        chk("first_count", 32'(fq.size()), 32'd1);
        if (fq.size() > 0) begin
            chk("first_frame", 32'(fq[0]), 32'(model_frame(0, '0, 1'b0, 1'b1, 1'b0, 0)));
            chk("first_bits", 32'(bq[0]), 32'(F));
        end

        apply(123456, 6'b000000, 1'b0, 1'b1, 1'b0); check_frames(7, "d123456");
        apply(42,     6'b000000, 1'b0, 1'b1, 1'b1); check_frames(6, "d42_lz");
        apply(42,     6'b000000, 1'b0, 1'b1, 1'b0); check_frames(6, "d42_nolz");
        apply(0,      6'b000000, 1'b0, 1'b1, 1'b1); check_frames(6, "d0_lz");
        apply(42,     6'b000010, 1'b1, 1'b1, 1'b1); check_frames(6, "d42_sign");
        apply(1000000,6'b000000, 1'b0, 1'b1, 1'b0); check_frames(6, "ovf");
        apply(1000000,6'b101010, 1'b0, 1'b1, 1'b1); check_frames(6, "ovf_pt");
        apply(999999, 6'b000000, 1'b0, 1'b1, 1'b1); check_frames(6, "max");
        apply(123456, 6'b111111, 1'b1, 1'b0, 1'b1); check_frames(6, "dark");

        for (int r = 0; r < 5; r++) begin
            d = (r % 3 == 2) ? $urandom_range(1000000, 1048575) : $urandom_range(0, 999999);
            apply(d, NUM_DIG'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
            check_frames(6, "rand");
        end

        // data change while a frame is in flight
        apply(111111, 6'b000000, 1'b0, 1'b1, 1'b0);
        sync_in_frame();
        @(posedge sys_clk);
        fq.delete(); bq.delete(); tq.delete();
        @(negedge sys_clk);
        data = DATA_W'(999999);
        wait_rises(2);
        chk("mid_count", 32'(fq.size() >= 2), 32'd1);
        if (fq.size() >= 2) begin
            chk("mid_old", 32'(fq[0]), 32'(model_frame(111111, '0, 1'b0, 1'b1, 1'b0, dig_of(fq[0]))));
            chk("mid_new", 32'(fq[1]), 32'(model_frame(999999, '0, 1'b0, 1'b1, 1'b0, dig_of(fq[1]))));
        end

        // reset pulsed mid-frame
        sync_in_frame();
        r0 = stcp_rises;
        sys_rst = 1'b1;
        adv(3);
        chk("mrst_ds", 32'(ds), 32'd0);
        chk("mrst_shcp", 32'(shcp), 32'd0);
        chk("mrst_stcp", 32'(stcp), 32'd0);
        chk("mrst_oe", 32'(oe), 32'd1);
        sys_rst = 1'b0;
        adv(50);
        chk("mrst_no_stcp", 32'(stcp_rises), 32'(r0));
        @(posedge sys_clk);
        fq.delete(); bq.delete(); tq.delete();
        wait_rises(1);
        if (fq.size() >= 1) begin
            chk("mrst_frame", 32'(fq[0]), 32'(model_frame(0, '0, 1'b0, 1'b1, 1'b0, 0)));
            chk("mrst_bits", 32'(bq[0]), 32'(F));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/seg_595_scan_multi.md
# seg_595_scan_multi

Parametrised dynamic-scan seven-segment driver for 74HC595-chained displays, the successor to the fixed six-digit scan driver. It takes a binary value plus per-digit decimal points, a sign flag and an enable, and converts the value to BCD internally with a sequential double-dabble. It adds leading-zero blanking and overflow indication. It serialises one digit frame per scan slot to the shift-register chain, sitting between a data source and the board's 595 pins.

## Interface
- NUM_DIG, 6, digit count, 1..8
- DATA_W, 20, binary input width; 2^DATA_W−1 must be ≥ 10^NUM_DIG−1
- SCAN_CNT, 50_000, sys_clk cycles per digit slot; must be > (8+NUM_DIG)·2·CLK_DIV + CLK_DIV + 2
- CLK_DIV, 2, sys_clk cycles per shcp half-period, ≥1
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- data  in  DATA_W  unsigned value to display
- point  in  NUM_DIG  decimal point per digit, active-high, bit i = digit i (digit 0 rightmost)
- sign  in  1  1 = show '-' in digit NUM_DIG−1
- seg_en  in  1  0 = all segments dark
- lz_blank  in  1  1 = blank leading zeros
- ds  out  1  serial data to 595
- shcp  out  1  595 shift clock
- stcp  out  1  595 storage (latch) clock
- oe  out  1  595 output enable, active-low

## Operation
- Segment codes are common-anode, active-low, bit7=dp ... bit0=a: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, '-' BF, blank FF. A point clears bit7.
- BCD converter FSM states: IDLE → LOAD (capture data) → SHIFT (DATA_W cycles, add-3 then shift) → DONE (atomic write of NUM_DIG BCD digits + ovf flag) → IDLE. It free-runs, so the result refreshes every DATA_W+3 cycles. The display reads only the DONE-updated register, never a partial result.
- ovf = captured data > 10^NUM_DIG−1. When ovf, every digit shows '-' (BF), with points still applied.
- Per-digit code priority: seg_en=0 → FF; else ovf → BF; else sign and i=NUM_DIG−1 → BF; else lz_blank and i>0 and all BCD digits i..NUM_DIG−1 are zero → FF; else the BCD code. The point is applied after, except when seg_en=0.
- Scan: slot counter 0..SCAN_CNT−1, digit index 0..NUM_DIG−1 wrapping to 0. The index advances at slot end.
- Frame = {seg[7:0], sel[NUM_DIG−1:0]}, F = 8+NUM_DIG bits, sent MSB first. sel is one-hot active-high, bit i = digit i.
- The frame is captured from the current digit state at slot count 0. Input changes during transmission do not affect the frame in flight.
- oe = 1 in reset, 0 from the first sys_clk edge after release.

## Timing
- Cycle 0 = cycle with slot count 0. All outputs are registered and change one cycle after the governing count value.
- Bit k (0..F−1) is held on ds for count [2kD, 2(k+1)D), where D = CLK_DIV.
- shcp is low for the first D cycles and high for the next D cycles of each bit, so the rising edge falls mid-bit.
- After bit F−1: ds=0, shcp=0, and stcp=1 for count [2FD, 2FD+D), then 0 until the next slot.
- Reset values: ds=0, shcp=0, stcp=0, oe=1, slot count 0, digit index 0, BCD register 0, ovf 0, converter IDLE.
- First slot after reset release starts at count 0 with digit 0. It shows BCD 0 until the first DONE (DATA_W+3 cycles).
- Reset asserted mid-frame: outputs go to reset values immediately. No stcp pulse is issued for the aborted frame.

## Test plan
- Reset held 10 cycles, then released → ds=0, shcp=0, stcp=0, oe=1 during reset. oe=0 one cycle after release. Exactly F rising shcp edges and 1 stcp pulse per slot (NUM_DIG=6, SCAN_CNT=200, CLK_DIV=2).
- data=123456, lz_blank=0, point=0, sign=0, seg_en=1 → digit0 frame seg=82 sel=000001; digit5 frame seg=F9 sel=100000. Digits cycle 0..5 and wrap.
- data=42, lz_blank=1 → digits 5..2 = FF, digit1 = 99, digit0 = A4. With lz_blank=0, digit2 = C0. data=0 with lz_blank=1 → digit0 = C0.
- data=42, sign=1, point=000010 → digit5 = BF, digit1 = 19, digit0 = A4.
- data=1_000_000 → all six digits BF. seg_en=0 with point=111111 → all digits FF.
- data changes from 111111 to 999999 mid-frame → the current frame carries old digit codes. Later slots show 90 after the next DONE. Reset pulsed mid-frame → no stcp for that frame; restart at digit 0.
